// File: rtl/cfg_write_arbiter_if.sv
// cfg_write_arbiter_if: host and auto single-byte write ports with ready and drop-error pulses
interface cfg_write_arbiter_if;
  logic       host_valid;
  logic [6:0] host_addr;
  logic [7:0] host_data;
  logic       host_ready;
  logic       host_err;
  logic       auto_valid;
  logic [6:0] auto_addr;
  logic [7:0] auto_data;
  logic       auto_ready;
  logic       auto_err;
  modport slave (
    input  host_valid, host_addr, host_data, auto_valid, auto_addr, auto_data,
    output host_ready, host_err, auto_ready, auto_err
  );
  modport master (
    output host_valid, host_addr, host_data, auto_valid, auto_addr, auto_data,
    input  host_ready, host_err, auto_ready, auto_err
  );
endinterface

// File: rtl/cfg_write_arbiter.sv
// cfg_write_arbiter: host-priority config write arbiter with auto-port starvation guard; CFG_LOCK_EN adds a host-only auto-write lock at 0x05
module cfg_write_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  cfg_write_arbiter_if.slave  bus,
  output logic [7:0]          en_reg_out_7_0,
  output logic [7:0]          en_reg_out_15_8,
  output logic [7:0]          en_reg_pwm_7_0,
  output logic [7:0]          en_reg_pwm_15_8,
  output logic [7:0]          pwm_duty_cycle,
  output logic [7:0]          conflict_cnt
);
  typedef enum logic {HOST_PRI, AUTO_PRI} state_e;
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  state_e          state_q, state_d;
  logic [3:0]      wait_q, wait_d;
  logic [4:0][7:0] regs_q;
  logic [7:0]      conflict_q;
  logic            host_err_q, auto_err_q;
  logic            grant_host, grant_auto;
  logic            host_ok, auto_ok, lock_q;
  logic            wr_en;
  logic [2:0]      wr_addr;
  logic [7:0]      wr_data;
`ifdef CFG_LOCK_EN
  // Lock bit: only the host may set or clear it
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) lock_q <= 1'b0;
    else if (grant_host && bus.host_addr == 7'd5) lock_q <= bus.host_data[0];
  assign host_ok = bus.host_addr <= 7'd5;
`else
  assign lock_q  = 1'b0;
  assign host_ok = bus.host_addr < 7'd5;
`endif
  assign auto_ok = bus.auto_addr < 7'd5 && !lock_q;
  // Grant selection, starvation counting and priority hand-over
  always_comb begin
    grant_auto = bus.auto_valid && (state_q == AUTO_PRI || !bus.host_valid);
    grant_host = bus.host_valid && !grant_auto;
    wait_d     = (bus.auto_valid && !grant_auto) ? wait_q + 4'd1 : 4'd0;
    state_d    = state_q;
    if (state_q == HOST_PRI) state_d = (wait_d == LIMIT) ? AUTO_PRI : HOST_PRI;
    else state_d = (grant_auto || !bus.auto_valid) ? HOST_PRI : AUTO_PRI;
    wr_en   = (grant_host && host_ok && bus.host_addr < 7'd5) || (grant_auto && auto_ok);
    wr_addr = grant_host ? bus.host_addr[2:0] : bus.auto_addr[2:0];
    wr_data = grant_host ? bus.host_data : bus.auto_data;
  end
  assign bus.host_ready = rst_n && grant_host;
  assign bus.auto_ready = rst_n && grant_auto;
  assign bus.host_err   = host_err_q;
  assign bus.auto_err   = auto_err_q;
  // Arbiter state and starvation counter
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= HOST_PRI;
      wait_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  // Register file writes, drop-error pulses and saturating conflict counter
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      regs_q     <= '0;
      host_err_q <= 1'b0;
      auto_err_q <= 1'b0;
      conflict_q <= 8'd0;
    end else begin
      if (wr_en) regs_q[wr_addr] <= wr_data;
      host_err_q <= grant_host && !host_ok;
      auto_err_q <= grant_auto && !auto_ok;
      if (bus.host_valid && bus.auto_valid && conflict_q != 8'hFF) conflict_q <= conflict_q + 8'd1;
    end
  assign en_reg_out_7_0  = regs_q[0];
  assign en_reg_out_15_8 = regs_q[1];
  assign en_reg_pwm_7_0  = regs_q[2];
  assign en_reg_pwm_15_8 = regs_q[3];
  assign pwm_duty_cycle  = regs_q[4];
  assign conflict_cnt    = conflict_q;
endmodule

// File: tb/tb_cfg_write_arbiter.sv
// tb_cfg_write_arbiter: directed and randomized checks against a register/arbitration reference model
module tb_cfg_write_arbiter;
  localparam int STARVE = 4;
`ifdef CFG_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle, conflict_cnt;
  cfg_write_arbiter_if bus();
  cfg_write_arbiter #(.STARVE_LIMIT(STARVE)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
    .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
    .pwm_duty_cycle(pwm_duty_cycle), .conflict_cnt(conflict_cnt)
  );
  always #5 clk = ~clk;
  int checks = 0;
  int failures = 0;
  logic [7:0] m_reg [5];
  bit m_lock, m_turn, m_herr, m_aerr, e_gh, e_ga;
  int m_wait, m_conf;
  wire [39:0] dut_regs = {pwm_duty_cycle, en_reg_pwm_15_8, en_reg_pwm_7_0, en_reg_out_15_8, en_reg_out_7_0};
  wire [39:0] exp_regs = {m_reg[4], m_reg[3], m_reg[2], m_reg[1], m_reg[0]};

  task automatic model_clear();
    for (int i = 0; i < 5; i++) m_reg[i] = 8'h00;
    m_lock = 0; m_turn = 0; m_herr = 0; m_aerr = 0; m_wait = 0; m_conf = 0; e_gh = 0; e_ga = 0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.host_valid = 0; bus.auto_valid = 0;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drive(input bit hv, input logic [6:0] ha, input logic [7:0] hd,
                       input bit av, input logic [6:0] aa, input logic [7:0] ad);
    @(negedge clk);
    bus.host_valid = hv; bus.host_addr = ha; bus.host_data = hd;
    bus.auto_valid = av; bus.auto_addr = aa; bus.auto_data = ad;
    e_ga = av && (m_turn || !hv);
    e_gh = hv && !e_ga;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    m_herr = 0; m_aerr = 0;
    if (e_gh) begin
      if (bus.host_addr < 5) m_reg[bus.host_addr[2:0]] = bus.host_data;
      else if (LOCK && bus.host_addr == 5) m_lock = bus.host_data[0];
      else m_herr = 1;
    end
    if (e_ga) begin
      if (bus.auto_addr < 5 && !m_lock) m_reg[bus.auto_addr[2:0]] = bus.auto_data;
      else m_aerr = 1;
    end
    if (bus.host_valid && bus.auto_valid && m_conf < 255) m_conf++;
    m_wait = (bus.auto_valid && !e_ga) ? m_wait + 1 : 0;
    m_turn = !m_turn && m_wait == STARVE;
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.host_valid = 1; bus.host_addr = 0; bus.host_data = 8'hAA;
    bus.auto_valid = 1; bus.auto_addr = 1; bus.auto_data = 8'h55;
    model_clear();
    #1;
    checks++; if ({bus.host_ready, bus.auto_ready} !== 2'b00) begin failures++; $display("FAIL reset_ready got=%b want=00", {bus.host_ready, bus.auto_ready}); end
    @(posedge clk); #1;
    checks++; if (dut_regs !== 40'h0) begin failures++; $display("FAIL reset_regs got=%h want=0", dut_regs); end
    checks++; if (conflict_cnt !== 8'h00) begin failures++; $display("FAIL reset_conflict got=%h want=00", conflict_cnt); end
    checks++; if ({bus.host_err, bus.auto_err} !== 2'b00) begin failures++; $display("FAIL reset_err got=%b want=00", {bus.host_err, bus.auto_err}); end
    @(negedge clk);
    bus.host_valid = 0; bus.auto_valid = 0;
    rst_n = 1'b1;
  endtask

  task automatic test_host_write();
    apply_reset();
    drive(1, 7'h04, 8'h80, 0, 7'h00, 8'h00);
    checks++; if ({bus.host_ready, bus.auto_ready} !== 2'b10) begin failures++; $display("FAIL host_ready got=%b want=10", {bus.host_ready, bus.auto_ready}); end
    checks++; if (pwm_duty_cycle !== 8'h00) begin failures++; $display("FAIL host_pre_edge got=%h want=00", pwm_duty_cycle); end
    tick();
    checks++; if (pwm_duty_cycle !== 8'h80) begin failures++; $display("FAIL host_duty got=%h want=80", pwm_duty_cycle); end
    checks++; if (bus.host_err !== 1'b0) begin failures++; $display("FAIL host_noerr got=%b want=0", bus.host_err); end
  endtask

  task automatic test_starvation();
    bit exp_h;
    apply_reset();
    for (int i = 0; i < 12; i++) begin
      drive(1, 7'h00, 8'(i), 1, 7'h01, 8'(~i));
      exp_h = (i % (STARVE + 1)) != STARVE;
      checks++; if ({bus.host_ready, bus.auto_ready} !== {exp_h, !exp_h}) begin failures++; $display("FAIL starve_grant cycle=%0d got=%b want=%b", i, {bus.host_ready, bus.auto_ready}, {exp_h, !exp_h}); end
      tick();
    end
    checks++; if (conflict_cnt !== 8'd12) begin failures++; $display("FAIL starve_conflict got=%0d want=12", conflict_cnt); end
    checks++; if ({en_reg_out_15_8, en_reg_out_7_0} !== 16'hF60B) begin failures++; $display("FAIL starve_regs got=%h want=f60b", {en_reg_out_15_8, en_reg_out_7_0}); end
  endtask

  task automatic test_bad_addr();
    apply_reset();
    drive(1, 7'h07, 8'hFF, 0, 7'h00, 8'h00);
    checks++; if (bus.host_ready !== 1'b1) begin failures++; $display("FAIL bad_host_ready got=%b want=1", bus.host_ready); end
    checks++; if (bus.host_err !== 1'b0) begin failures++; $display("FAIL bad_host_err_early got=%b want=0", bus.host_err); end
    tick();
    checks++; if (bus.host_err !== 1'b1) begin failures++; $display("FAIL bad_host_err got=%b want=1", bus.host_err); end
    checks++; if (dut_regs !== 40'h0) begin failures++; $display("FAIL bad_host_regs got=%h want=0", dut_regs); end
    drive(0, 7'h00, 8'h00, 1, 7'h45, 8'h12);
    tick();
    checks++; if ({bus.host_err, bus.auto_err} !== 2'b01) begin failures++; $display("FAIL bad_auto_err got=%b want=01", {bus.host_err, bus.auto_err}); end
    drive(0, 7'h00, 8'h00, 0, 7'h00, 8'h00);
    tick();
    checks++; if ({bus.host_err, bus.auto_err} !== 2'b00) begin failures++; $display("FAIL bad_err_width got=%b want=00", {bus.host_err, bus.auto_err}); end
    drive(1, 7'h05, 8'h01, 0, 7'h00, 8'h00);
    tick();
    checks++; if (bus.host_err !== !LOCK) begin failures++; $display("FAIL addr5_host_err got=%b want=%b", bus.host_err, !LOCK); end
  endtask

  task automatic test_conflict_sat();
    apply_reset();
    for (int i = 0; i < 260; i++) begin
      drive(1, 7'h03, 8'(i), 1, 7'h02, 8'(i + 1));
      tick();
    end
    checks++; if (conflict_cnt !== 8'hFF) begin failures++; $display("FAIL conflict_sat got=%h want=ff", conflict_cnt); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int i = 0; i < STARVE; i++) begin
      drive(1, 7'h00, 8'h11, 1, 7'h01, 8'h22);
      tick();
    end
    @(negedge clk);
    rst_n = 1'b0;
    model_clear();
    #1;
    checks++; if ({bus.host_ready, bus.auto_ready} !== 2'b00) begin failures++; $display("FAIL mid_ready got=%b want=00", {bus.host_ready, bus.auto_ready}); end
    checks++; if (dut_regs !== 40'h0 || conflict_cnt !== 8'h00) begin failures++; $display("FAIL mid_clear regs=%h conflict=%h want=0", dut_regs, conflict_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 7'h00, 8'h33, 1, 7'h01, 8'h44);
    checks++; if ({bus.host_ready, bus.auto_ready} !== 2'b10) begin failures++; $display("FAIL mid_first_grant got=%b want=10", {bus.host_ready, bus.auto_ready}); end
    tick();
  endtask

`ifdef CFG_LOCK_EN
  task automatic test_lock();
    apply_reset();
    drive(1, 7'h05, 8'h01, 0, 7'h00, 8'h00);
    tick();
    checks++; if (bus.host_err !== 1'b0) begin failures++; $display("FAIL lock_set_err got=%b want=0", bus.host_err); end
    drive(0, 7'h00, 8'h00, 1, 7'h02, 8'h55);
    checks++; if (bus.auto_ready !== 1'b1) begin failures++; $display("FAIL lock_auto_ready got=%b want=1", bus.auto_ready); end
    tick();
    checks++; if (en_reg_pwm_7_0 !== 8'h00) begin failures++; $display("FAIL lock_pwm got=%h want=00", en_reg_pwm_7_0); end
    checks++; if (bus.auto_err !== 1'b1) begin failures++; $display("FAIL lock_auto_err got=%b want=1", bus.auto_err); end
  endtask
`endif

  task automatic test_random();
    bit hp, ap;
    logic [6:0] ha, aa;
    logic [7:0] hd, ad;
    apply_reset();
    hp = 0; ap = 0; ha = 0; aa = 0; hd = 0; ad = 0;
    for (int n = 0; n < 3000; n++) begin
      if (!hp && $urandom_range(0, 2) != 0) begin
        hp = 1; hd = 8'($urandom);
        ha = ($urandom_range(0, 15) == 0) ? 7'($urandom) : 7'($urandom_range(0, 6));
      end
      if (!ap && $urandom_range(0, 2) != 0) begin
        ap = 1; ad = 8'($urandom);
        aa = ($urandom_range(0, 15) == 0) ? 7'($urandom) : 7'($urandom_range(0, 6));
      end
      drive(hp, ha, hd, ap, aa, ad);
      checks++; if ({bus.host_ready, bus.auto_ready} !== {e_gh, e_ga}) begin failures++; $display("FAIL rand_grant cycle=%0d got=%b want=%b", n, {bus.host_ready, bus.auto_ready}, {e_gh, e_ga}); end
      if (e_gh) hp = 0;
      if (e_ga) ap = 0;
      tick();
      checks++; if (dut_regs !== exp_regs) begin failures++; $display("FAIL rand_regs cycle=%0d got=%h want=%h", n, dut_regs, exp_regs); end
      checks++; if ({bus.host_err, bus.auto_err} !== {m_herr, m_aerr}) begin failures++; $display("FAIL rand_err cycle=%0d got=%b want=%b", n, {bus.host_err, bus.auto_err}, {m_herr, m_aerr}); end
      checks++; if (conflict_cnt !== 8'(m_conf)) begin failures++; $display("FAIL rand_conflict cycle=%0d got=%0d want=%0d", n, conflict_cnt, m_conf); end
    end
  endtask

  initial begin
    bus.host_valid = 0; bus.host_addr = 0; bus.host_data = 0;
    bus.auto_valid = 0; bus.auto_addr = 0; bus.auto_data = 0;
    model_clear();
    test_reset();
    test_host_write();
    test_starvation();
    test_bad_addr();
    test_conflict_sat();
    test_reset_mid();
`ifdef CFG_LOCK_EN
    test_lock();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
